datastream_pattern_analyzer: RTL

Parametrised successor to the single-channel datastream input stage. Accepts words on a valid/ready datastream port and buffers them in an internal FIFO. Forwards them in order on a valid/ready output port, tagging each word that completes a programmable PATTERN_LEN-word sequence. Keeps a saturating match counter. Sits between the datastream sender and downstream consumers in the analyzer datapath.

---
 rtl/datastream_pattern_analyzer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/datastream_pattern_analyzer.sv
// Datastream input stage: buffers valid/ready words in a FIFO, forwards them in order
// and tags each word that completes a programmable PATTERN_LEN-word sequence.
module datastream_pattern_analyzer #(
  parameter int unsigned DATASIZE    = 8,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned PATTERN_LEN = 3,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [DATASIZE-1:0]               data_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [PATTERN_LEN*DATASIZE-1:0]   pattern_i,
  input  logic                              clear_i,
  output logic [DATASIZE-1:0]               data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic                              match_o,
  output logic [COUNT_WIDTH-1:0]            match_count_o,
  output logic [$clog2(FIFO_DEPTH):0]       fill_o
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FW  = AW + 1;
  localparam int unsigned HL  = (PATTERN_LEN > 1) ? PATTERN_LEN - 1 : 1;
  localparam int unsigned HCW = $clog2(PATTERN_LEN + 1);
  localparam logic [HCW-1:0]         HFULL   = HCW'(PATTERN_LEN - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATASIZE-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [FW-1:0]          fill;
  logic                   push_c;
  logic                   pop_c;
  logic                   match_c;
  logic [DATASIZE-1:0]    head_c;
  logic [DATASIZE-1:0]    hist [HL];
  logic [HCW-1:0]         hcnt;
  logic [HCW-1:0]         hcnt_eff_c;
  logic [DATASIZE-1:0]    win [PATTERN_LEN];
  logic [COUNT_WIDTH-1:0] match_count;

  // Full FIFO never advertises ready, even when a pop would free a slot this cycle.
  assign ready_o       = !rst_i && (fill < FW'(FIFO_DEPTH));
  assign push_c        = valid_i && ready_o;
  assign pop_c         = (fill != '0) && (!valid_o || ready_i);
  assign head_c        = mem[rd_ptr];
  assign fill_o        = fill;
  assign match_count_o = match_count;

  // Comparison window: oldest history word in slot 0, the head word in the last slot.
  for (genvar i = 0; i < int'(PATTERN_LEN); i++) begin : g_win
    if (i < int'(PATTERN_LEN) - 1) begin : g_hist
      assign win[i] = hist[i];
    end else begin : g_head
      assign win[i] = head_c;
    end
  end

  // A clear in the pop cycle evaluates the pop against an empty history.
  always_comb begin
    hcnt_eff_c = clear_i ? '0 : hcnt;
    match_c    = (hcnt_eff_c == HFULL);
    for (int i = 0; i < int'(PATTERN_LEN); i++) begin
      if (win[i] != pattern_i[i*DATASIZE +: DATASIZE]) match_c = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      if (push_c && !pop_c)      fill <= fill + FW'(1);
      else if (!push_c && pop_c) fill <= fill - FW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_c) mem[wr_ptr] <= data_i;
  end

  // Output register holds its word until the consumer takes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o  <= '0;
      match_o <= 1'b0;
      valid_o <= 1'b0;
    end else if (pop_c) begin
      data_o  <= head_c;
      match_o <= match_c;
      valid_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      match_o <= 1'b0;
      valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcnt <= '0;
      for (int j = 0; j < int'(HL); j++) hist[j] <= '0;
    end else if (pop_c) begin
      for (int j = 0; j < int'(HL) - 1; j++) hist[j] <= hist[j+1];
      hist[HL-1] <= head_c;
      hcnt       <= (hcnt_eff_c == HFULL) ? hcnt_eff_c : hcnt_eff_c + HCW'(1);
    end else if (clear_i) begin
      hcnt <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      match_count <= '0;
    end else if (pop_c && match_c && (match_count != CNT_MAX)) begin
      match_count <= match_count + COUNT_WIDTH'(1);
    end
  end

endmodule
